// File: rtl/hash_chain_mc.sv
// Multi-channel rolling XOR/rotate hash. Each channel folds its beats into its own
// context, and the module emits one registered result per message end beat.
module hash_chain_mc #(
    parameter int DATA_W    = 128,
    parameter int CHANNELS  = 4,
    parameter int ROT       = 1,
    parameter int BIT_START = 9,
    parameter int BIT_END   = 8,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CH_W-1:0]   chan_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CH_W-1:0]   chan_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              err_o
);

    localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(CHANNELS);

    logic [DATA_W-1:0]   state_q [CHANNELS];
    logic [CHANNELS-1:0] active_q;

    logic              accept;
    logic              chan_ok;
    logic              is_start;
    logic              is_end;
    logic              chan_active;
    logic              proto_err;
    logic [DATA_W-1:0] cur_state;
    logic [DATA_W-1:0] rot_state;
    logic [DATA_W-1:0] next_hash;

    // Handshake: a beat transfers on a rising edge with valid_i && ready_o, and a
    // result transfers with valid_o && ready_i. The output slot accepts a new beat
    // whenever it is empty or being drained in the same cycle.
    assign ready_o  = !valid_o || ready_i;
    assign accept   = valid_i && ready_o;
    assign chan_ok  = ({1'b0, chan_i} < CH_LIMIT);
    assign is_start = data_i[BIT_START];
    assign is_end   = data_i[BIT_END];

    always_comb begin
        cur_state   = '0;
        chan_active = 1'b0;
        if (chan_ok) begin
            cur_state   = state_q[chan_i];
            chan_active = active_q[chan_i];
        end
    end

    // With ROT == 0 the right shift is by DATA_W and contributes nothing: plain XOR.
    assign rot_state = (cur_state << ROT) | (cur_state >> (DATA_W - ROT));
    assign next_hash = is_start ? data_i : (data_i ^ rot_state);

    // Orphan beats (no start seen) and restarts of an open message are both flagged.
    always_comb begin
        proto_err = 1'b0;
        if (!chan_ok) begin
            proto_err = 1'b1;
        end else if (is_start) begin
            proto_err = chan_active;
        end else begin
            proto_err = !chan_active;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state_q[c] <= '0;
            end
            active_q <= '0;
        end else if (accept && chan_ok) begin
            state_q[chan_i] <= next_hash;
            if (is_end) begin
                active_q[chan_i] <= 1'b0;
            end else if (is_start) begin
                active_q[chan_i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_o  <= '0;
            chan_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            err_o <= accept && proto_err;
            if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
            if (accept && chan_ok && is_end) begin
                data_o  <= next_hash;
                chan_o  <= chan_i;
                valid_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hash_chain_mc.sv
// Bench for hash_chain_mc: directed scenarios plus random traffic checked against a
// per-channel message model and a queue of expected results.
module tb_hash_chain_mc;

    localparam int DATA_W = 128;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] data_i;
    logic [1:0]        chan_i;
    logic              valid_i;
    logic              ready_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        chan_o;
    logic              valid_o;
    logic              ready_i;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_state [4];
    bit                m_active [4];
    logic [DATA_W+1:0] exp_q[$];

    hash_chain_mc dut (
        .clk     (clk),
        .rst     (rst),
        .data_i  (data_i),
        .chan_i  (chan_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .chan_o  (chan_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .err_o   (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] rotl_model(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) begin
            r[(i + 1) % DATA_W] = x[i];
        end
        return r;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_state[c]  = '0;
            m_active[c] = 0;
        end
        exp_q.delete();
    endtask

    // One clock: drive at the negedge, predict, then inspect outputs at the next negedge.
    task automatic cycle(input bit v, input logic [1:0] ch, input logic [DATA_W-1:0] d, input bit rdy);
        bit                exp_ready;
        bit                acc;
        bit                exp_err;
        logic [DATA_W-1:0] h;
        valid_i = v;
        chan_i  = ch;
        data_i  = d;
        ready_i = rdy;
        #1;
        exp_ready = (exp_q.size() == 0) || rdy;
        checks++;
        if (ready_o !== exp_ready) begin
            errors++;
            $display("FAIL ready_o: got %b expected %b at %0t", ready_o, exp_ready, $time);
        end
        acc = v && exp_ready;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        exp_err = 0;
        if (acc) begin
            if (d[9]) begin
                exp_err = m_active[ch];
                h = d;
            end else begin
                exp_err = !m_active[ch];
                h = d ^ rotl_model(m_state[ch]);
            end
            m_state[ch] = h;
            if (d[8]) m_active[ch] = 0;
            else if (d[9]) m_active[ch] = 1;
            if (d[8]) exp_q.push_back({ch, h});
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL err_o: got %b expected %b at %0t", err_o, exp_err, $time);
        end
        checks++;
        if (valid_o !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL valid_o: got %b expected %b at %0t", valid_o, exp_q.size() != 0, $time);
        end
        if (exp_q.size() != 0) begin
            checks++;
            if ({chan_o, data_o} !== exp_q[0]) begin
                errors++;
                $display("FAIL output: got ch%0d %h expected ch%0d %h at %0t",
                         chan_o, data_o, exp_q[0][DATA_W+1:DATA_W], exp_q[0][DATA_W-1:0], $time);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 2'd0, '0, 1);
    endtask

    task automatic check_literal(input string name, input logic [DATA_W-1:0] exp_d, input logic [1:0] exp_c);
        checks++;
        if (valid_o !== 1'b1 || data_o !== exp_d || chan_o !== exp_c) begin
            errors++;
            $display("FAIL %s: got v=%b ch%0d %h expected v=1 ch%0d %h", name, valid_o, chan_o, data_o, exp_c, exp_d);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (valid_o !== 1'b0 || data_o !== '0 || chan_o !== 2'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s: got v=%b ch%0d d=%h err=%b expected all zero", name, valid_o, chan_o, data_o, err_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;
        model_clear();
        idle(1);
    endtask

    task automatic test_single();
        cycle(1, 2'd0, 128'h300, 1);
        check_literal("single_beat", 128'h300, 2'd0);
        idle(1);
    endtask

    task automatic test_chain();
        cycle(1, 2'd1, 128'h200, 1);
        cycle(1, 2'd1, 128'h100, 1);
        check_literal("chain_ch1", 128'h500, 2'd1);
        idle(1);
    endtask

    task automatic test_wrap();
        cycle(1, 2'd2, 128'h8000_0000_0000_0000_0000_0000_0000_0200, 1);
        cycle(1, 2'd2, 128'h100, 1);
        check_literal("wrap_ch2", 128'h501, 2'd2);
        idle(1);
    endtask

    task automatic test_interleave();
        cycle(1, 2'd0, 128'h200, 1);
        cycle(1, 2'd3, 128'h200, 1);
        cycle(1, 2'd0, 128'h100, 1);
        check_literal("interleave_ch0", 128'h500, 2'd0);
        cycle(1, 2'd3, 128'h300, 1);
        idle(1);
    endtask

    task automatic test_stall();
        cycle(1, 2'd1, 128'h300, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 2'd2, 128'h100, 0);
            check_literal("stall_hold", 128'h300, 2'd1);
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        cycle(1, 2'd0, 128'h300, 1);
        cycle(1, 2'd1, 128'h355, 1);
        cycle(1, 2'd2, 128'h3aa, 1);
        check_literal("back_to_back", 128'h3aa, 2'd2);
        idle(1);
    endtask

    task automatic test_reset_mid();
        cycle(1, 2'd0, 128'h200, 1);
        cycle(1, 2'd1, 128'h300, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        model_clear();
        cycle(1, 2'd0, 128'h100, 1);
        check_literal("orphan_after_reset", 128'h100, 2'd0);
        idle(1);
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] d;
        for (int i = 0; i < 300; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            d[9] = ($urandom_range(0, 3) == 0);
            d[8] = ($urandom_range(0, 2) == 0);
            cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), d, $urandom_range(0, 9) < 7);
        end
        idle(3);
    endtask

    initial begin
        rst     = 1'b1;
        data_i  = '0;
        chan_i  = '0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        model_clear();
        @(negedge clk);
        test_reset();
        test_single();
        test_chain();
        test_wrap();
        test_interleave();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
